// File: rtl/ervp_small_fifo_ext.sv
// Register-based small FIFO with occupancy count, look-ahead ready vectors,
// programmable almost-full/empty thresholds, optional empty bypass and sticky error flags.
module ervp_small_fifo_ext #(
    parameter int unsigned BW_DATA            = 8,
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned READ_READY_SIZE    = 1,
    parameter int unsigned WRITE_READY_SIZE   = 1,
    parameter int unsigned BYPASS             = 0,
    parameter int unsigned ALMOST_FULL_LEVEL  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1,
    localparam int unsigned BW_COUNT          = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rstnn,
    input  logic                        enable,
    input  logic                        clear,
    output logic [WRITE_READY_SIZE-1:0] wready,
    output logic                        wfull,
    input  logic                        wrequest,
    input  logic [BW_DATA-1:0]          wdata,
    output logic [READ_READY_SIZE-1:0]  rready,
    output logic                        rempty,
    input  logic                        rrequest,
    output logic [BW_DATA-1:0]          rdata,
    output logic [BW_COUNT-1:0]         count,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned BW_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BW_DATA-1:0]  mem_q [DEPTH];
    logic [BW_PTR-1:0]   wptr_q, wptr_d;
    logic [BW_PTR-1:0]   rptr_q, rptr_d;
    logic [BW_COUNT-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                write_en;
    logic                bypass_hit;
    logic                push;
    logic                pop;
    logic                pass_through;

    // Binary pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two)
    function automatic logic [BW_PTR-1:0] ptr_inc(input logic [BW_PTR-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + BW_PTR'(1);
    endfunction

    assign bypass_hit   = (BYPASS != 0) && (count_q == '0) && wrequest && !clear;
    assign push         = enable && wrequest && wready[0];
    assign pop          = enable && rrequest && rready[0];
    assign pass_through = bypass_hit && push && pop;

    // Look-ahead ready vectors decoded from occupancy; bits beyond DEPTH decode to 0
    always_comb begin
        for (int unsigned j = 0; j < WRITE_READY_SIZE; j++) begin
            wready[j] = !clear && ((32'(count_q) + j + 32'd1) <= DEPTH);
        end
        for (int unsigned j = 0; j < READ_READY_SIZE; j++) begin
            rready[j] = (32'(count_q) >= (j + 32'd1));
        end
        rready[0] = rready[0] | bypass_hit;
    end

    assign wfull        = ~wready[0];
    assign rempty       = ~rready[0];
    assign rdata        = bypass_hit ? wdata : mem_q[rptr_q];
    assign count        = count_q;
    assign almost_full  = (32'(count_q) >= ALMOST_FULL_LEVEL);
    assign almost_empty = (32'(count_q) <= ALMOST_EMPTY_LEVEL);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Next-state for pointers, occupancy and error flags
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        write_en = 1'b0;
        if (enable) begin
            if (clear) begin
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
            end else begin
                if (push && !pass_through) begin
                    wptr_d   = ptr_inc(wptr_q);
                    write_en = 1'b1;
                end
                if (pop && !pass_through) begin
                    rptr_d = ptr_inc(rptr_q);
                end
                count_d = count_q + BW_COUNT'(push) - BW_COUNT'(pop);
                if (wrequest && wfull) begin
                    ovf_d = 1'b1;
                end
                if (rrequest && rempty) begin
                    udf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage survives clear; only reset zeroes it
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_en) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_ervp_small_fifo_ext.sv
// Scoreboard bench for ervp_small_fifo_ext: three configurations (lookahead, DEPTH=3 wrap, bypass).
module tb_ervp_small_fifo_ext;

    logic clk = 1'b0;
    logic rstnn;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    // Instance A: DEPTH=4, 3-bit look-ahead vectors
    logic       a_en, a_clr, a_wreq, a_rreq;
    logic [7:0] a_wdata, a_rdata;
    logic [2:0] a_wready, a_rready, a_count;
    logic       a_wfull, a_rempty, a_af, a_ae, a_ovf, a_udf;

    // Instance B: DEPTH=3
    logic       b_en, b_clr, b_wreq, b_rreq;
    logic [7:0] b_wdata, b_rdata;
    logic [0:0] b_wready, b_rready;
    logic [1:0] b_count;
    logic       b_wfull, b_rempty, b_af, b_ae, b_ovf, b_udf;

    // Instance C: DEPTH=4 with bypass
    logic       c_en, c_clr, c_wreq, c_rreq;
    logic [7:0] c_wdata, c_rdata;
    logic [0:0] c_wready, c_rready;
    logic [2:0] c_count;
    logic       c_wfull, c_rempty, c_af, c_ae, c_ovf, c_udf;

    ervp_small_fifo_ext #(.BW_DATA(8), .DEPTH(4), .READ_READY_SIZE(3), .WRITE_READY_SIZE(3), .BYPASS(0)) u_a (
        .clk(clk), .rstnn(rstnn), .enable(a_en), .clear(a_clr),
        .wready(a_wready), .wfull(a_wfull), .wrequest(a_wreq), .wdata(a_wdata),
        .rready(a_rready), .rempty(a_rempty), .rrequest(a_rreq), .rdata(a_rdata),
        .count(a_count), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_udf));

    ervp_small_fifo_ext #(.BW_DATA(8), .DEPTH(3)) u_b (
        .clk(clk), .rstnn(rstnn), .enable(b_en), .clear(b_clr),
        .wready(b_wready), .wfull(b_wfull), .wrequest(b_wreq), .wdata(b_wdata),
        .rready(b_rready), .rempty(b_rempty), .rrequest(b_rreq), .rdata(b_rdata),
        .count(b_count), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_udf));

    ervp_small_fifo_ext #(.BW_DATA(8), .DEPTH(4), .BYPASS(1)) u_c (
        .clk(clk), .rstnn(rstnn), .enable(c_en), .clear(c_clr),
        .wready(c_wready), .wfull(c_wfull), .wrequest(c_wreq), .wdata(c_wdata),
        .rready(c_rready), .rempty(c_rempty), .rrequest(c_rreq), .rdata(c_rdata),
        .count(c_count), .almost_full(c_af), .almost_empty(c_ae),
        .overflow(c_ovf), .underflow(c_udf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted read is compared against the scoreboard head
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstnn) begin
                if (a_en && a_rreq && a_rready[0]) begin
                    if (qa.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL a_unexpected_read: got %0h, expected no read", a_rdata);
                    end else begin
                        e = qa.pop_front();
                        chk("a_rdata", 32'(a_rdata), 32'(e));
                    end
                end
                if (b_en && b_rreq && b_rready[0]) begin
                    if (qb.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL b_unexpected_read: got %0h, expected no read", b_rdata);
                    end else begin
                        e = qb.pop_front();
                        chk("b_rdata", 32'(b_rdata), 32'(e));
                    end
                end
                if (c_en && c_rreq && c_rready[0]) begin
                    if (qc.size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL c_unexpected_read: got %0h, expected no read", c_rdata);
                    end else begin
                        e = qc.pop_front();
                        chk("c_rdata", 32'(c_rdata), 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        rstnn = 1'b0;
        a_en = 1'b1; a_clr = 1'b0; a_wreq = 1'b0; a_rreq = 1'b0; a_wdata = 8'h00;
        b_en = 1'b1; b_clr = 1'b0; b_wreq = 1'b0; b_rreq = 1'b0; b_wdata = 8'h00;
        c_en = 1'b1; c_clr = 1'b0; c_wreq = 1'b0; c_rreq = 1'b0; c_wdata = 8'h00;
        #1;
        chk("rst_a_count", 32'(a_count), 0);
        chk("rst_a_wready", 32'(a_wready), 7);
        chk("rst_a_wfull", 32'(a_wfull), 0);
        chk("rst_a_rready", 32'(a_rready), 0);
        chk("rst_a_rempty", 32'(a_rempty), 1);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_ae", 32'(a_ae), 1);
        chk("rst_a_flags", 32'({a_ovf, a_udf}), 0);
        chk("rst_b_wready", 32'(b_wready), 1);
        chk("rst_c_rempty", 32'(c_rempty), 1);
        #1 rstnn = 1'b1;
        tick;

        // Fill A with four words; look-ahead vectors checked at count=2
        for (int i = 0; i < 4; i++) begin
            a_wreq = 1'b1;
            a_wdata = 8'((i + 1) * 17);
            qa.push_back(a_wdata);
            @(negedge clk);
            if (i == 2) begin
                chk("a_wready_cnt2", 32'(a_wready), 3);
                chk("a_rready_cnt2", 32'(a_rready), 3);
            end
            tick;
        end
        a_wreq = 1'b0;
        @(negedge clk);
        chk("a_full_count", 32'(a_count), 4);
        chk("a_full_wfull", 32'(a_wfull), 1);
        chk("a_full_af", 32'(a_af), 1);
        chk("a_full_wready", 32'(a_wready), 0);
        chk("a_full_rready", 32'(a_rready), 7);
        tick;

        // Full: write held during a pop is refused, accepted next cycle
        a_wreq = 1'b1; a_wdata = 8'h55; a_rreq = 1'b1;
        @(negedge clk);
        chk("a_pop_cycle_wfull", 32'(a_wfull), 1);
        tick;
        a_rreq = 1'b0;
        qa.push_back(8'h55);
        @(negedge clk);
        chk("a_ovf_set", 32'(a_ovf), 1);
        chk("a_after_pop_count", 32'(a_count), 3);
        tick;
        a_wreq = 1'b0;
        @(negedge clk);
        chk("a_refill_count", 32'(a_count), 4);
        chk("a_ovf_sticky", 32'(a_ovf), 1);
        tick;

        a_rreq = 1'b1;
        repeat (4) tick;
        a_rreq = 1'b0;
        @(negedge clk);
        chk("a_drain_rempty", 32'(a_rempty), 1);
        chk("a_drain_count", 32'(a_count), 0);
        chk("a_drain_ae", 32'(a_ae), 1);
        chk("a_drain_af", 32'(a_af), 0);
        tick;

        // Underflow on empty read
        a_rreq = 1'b1;
        tick;
        a_rreq = 1'b0;
        @(negedge clk);
        chk("a_udf_set", 32'(a_udf), 1);
        chk("a_udf_count", 32'(a_count), 0);
        tick;

        // Clear flushes flags and gates wready while asserted
        a_clr = 1'b1; a_wreq = 1'b1; a_wdata = 8'h99;
        @(negedge clk);
        chk("a_clr_wready", 32'(a_wready), 0);
        chk("a_clr_wfull", 32'(a_wfull), 1);
        tick;
        a_clr = 1'b0; a_wreq = 1'b0;
        @(negedge clk);
        chk("a_clr_count", 32'(a_count), 0);
        chk("a_clr_flags", 32'({a_ovf, a_udf}), 0);
        chk("a_clr_wready_after", 32'(a_wready), 7);
        tick;

        // enable=0 freezes everything
        a_wreq = 1'b1; a_wdata = 8'hA1; qa.push_back(8'hA1);
        tick;
        a_wdata = 8'hA2; qa.push_back(8'hA2);
        tick;
        a_en = 1'b0; a_wdata = 8'hEE; a_rreq = 1'b1;
        repeat (5) tick;
        @(negedge clk);
        chk("a_frozen_count", 32'(a_count), 2);
        chk("a_frozen_rdata", 32'(a_rdata), 32'h0A1);
        chk("a_frozen_flags", 32'({a_ovf, a_udf}), 0);
        tick;
        a_en = 1'b1; a_wreq = 1'b0;
        tick;
        a_rreq = 1'b0; a_wreq = 1'b1; a_wdata = 8'h77;

        // Asynchronous reset mid-stream
        #2 rstnn = 1'b0;
        #1;
        chk("mid_rst_count", 32'(a_count), 0);
        chk("mid_rst_rempty", 32'(a_rempty), 1);
        chk("mid_rst_rready", 32'(a_rready), 0);
        chk("mid_rst_rdata", 32'(a_rdata), 0);
        chk("mid_rst_wready", 32'(a_wready), 7);
        chk("mid_rst_ae", 32'(a_ae), 1);
        a_wreq = 1'b0;
        qa.delete();
        #3 rstnn = 1'b1;
        tick;

        // DEPTH=3 wrap: two-deep prefill then simultaneous push/pop
        for (int k = 0; k < 12; k++) begin
            b_wreq = (k < 10);
            b_wdata = 8'(k);
            if (k < 10) qb.push_back(8'(k));
            b_rreq = (k >= 2);
            @(negedge clk);
            chk("b_count", 32'(b_count), (k < 2) ? k : ((k <= 10) ? 2 : 1));
            tick;
        end
        b_wreq = 1'b0; b_rreq = 1'b0;
        @(negedge clk);
        chk("b_final_count", 32'(b_count), 0);
        chk("b_flags", 32'({b_ovf, b_udf}), 0);
        tick;

        // Bypass: same-cycle fall-through leaves FIFO empty
        c_wreq = 1'b1; c_rreq = 1'b1; c_wdata = 8'h5A; qc.push_back(8'h5A);
        @(negedge clk);
        chk("c_byp_rready", 32'(c_rready), 1);
        chk("c_byp_rdata", 32'(c_rdata), 32'h05A);
        tick;
        c_wreq = 1'b0; c_rreq = 1'b0;
        @(negedge clk);
        chk("c_byp_count", 32'(c_count), 0);
        chk("c_byp_rempty", 32'(c_rempty), 1);
        tick;
        c_clr = 1'b1; c_wreq = 1'b1; c_rreq = 1'b1; c_wdata = 8'h3C;
        @(negedge clk);
        chk("c_clr_no_bypass", 32'(c_rready), 0);
        tick;
        c_clr = 1'b0; c_rreq = 1'b0; c_wdata = 8'h6B; qc.push_back(8'h6B);
        tick;
        c_wreq = 1'b0; c_rreq = 1'b1;
        @(negedge clk);
        chk("c_stored_count", 32'(c_count), 1);
        tick;
        c_rreq = 1'b0;
        @(negedge clk);
        chk("c_final_count", 32'(c_count), 0);
        tick;

        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        chk("qc_drained", 32'(qc.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
